apb_uart_host: RTL and testbench

- APB initiator (requester side) that drives apb_uart's APB completer port from a simple valid/ready command/response interface.
- Converts one command into one APB SETUP/ACCESS transfer and returns read data and error status.
- Intended use: connects an on-chip controller or sequencer to the UART register map (LCR, FCR, HCR, OCR, TDR, RDR …).
- One transfer outstanding at a time; a wait-state watchdog prevents a hung completer from stalling the requester.

---
 rtl/apb_uart_host.sv | 144 ++++++++++++++
 tb/tb_apb_uart_host.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_host.sv
// APB requester that turns one valid/ready command into one SETUP/ACCESS transfer
// and returns read data plus error/timeout status through a held response.
module apb_uart_host #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [3:0]        pstrb,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [3:0]          pstrb_q, pstrb_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        // saturating wait-state count including the current ACCESS cycle
        cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb : 4'h0;
                    cnt_d    = '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    state_d       = RESP;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    // pready has priority: the abort only fires on a cycle without it
                    if (TIMEOUT != 0 && cnt_inc == CNT_W'(TIMEOUT)) begin
                        state_d       = RESP;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= 4'h0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // APB strobes decode straight from the state register so reset drops them at once
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign cmd_ready   = cmd_ready_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_uart_host.sv
// Directed bench for apb_uart_host: queued expected APB beats and responses are
// checked by negedge monitors, with inline latency/backpressure/reset checks.
module tb_apb_uart_host;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              pclk = 1'b0;
    logic              preset = 1'b1;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err, rsp_timeout;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;
    logic              pready, pslverr;
    logic [DATA_W-1:0] prdata;

    always #5 pclk = ~pclk;

    apb_uart_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
        .prdata(prdata)
    );

    // completer model: inserts sl_waits wait states, or never answers when sl_never
    int          acc_n;
    int          sl_waits = 0;
    logic        sl_never = 1'b0;
    logic        sl_err = 1'b0;
    logic [31:0] sl_rdata = 32'h0;

    always @(posedge pclk or posedge preset) begin
        if (preset) acc_n <= 0;
        else if (psel && penable && !pready) acc_n <= acc_n + 1;
        else acc_n <= 0;
    end
    assign pready  = psel && penable && !sl_never && (acc_n >= sl_waits);
    assign pslverr = pready && sl_err;
    assign prdata  = sl_rdata;

    typedef struct {logic [31:0] rdata; logic err; logic tmo;} rsp_t;
    typedef struct {logic [11:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb;} apb_t;
    rsp_t rsp_q[$];
    apb_t apb_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int hs_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        rsp_t er;
        apb_t ea;
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                er = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, er.rdata);
                check("rsp_err", 32'(rsp_err), 32'(er.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(er.tmo));
            end
        end
        if (psel && penable && pready) begin
            check("apb_expected", 32'(apb_q.size() != 0), 32'd1);
            if (apb_q.size() != 0) begin
                ea = apb_q.pop_front();
                check("paddr", 32'(paddr), 32'(ea.addr));
                check("pwrite", 32'(pwrite), 32'(ea.wr));
                check("pwdata", pwdata, ea.wdata);
                check("pstrb", 32'(pstrb), 32'(ea.strb));
            end
        end
    end

    // call at a negedge; returns 1ns after the handshake edge
    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic push_apb, input logic push_rsp,
                         input logic [31:0] e_rdata, input logic e_err, input logic e_tmo);
        int guard = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
        while (!cmd_ready && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        check("cmd_accept_bound", 32'(guard < 50), 32'd1);
        if (push_apb) apb_q.push_back(apb_t'{a, wr, (wr ? d : 32'h0), (wr ? s : 4'h0)});
        if (push_rsp) rsp_q.push_back(rsp_t'{e_rdata, e_err, e_tmo});
        @(posedge pclk);
        #1;
        hs_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output int pen);
        int guard = 0;
        pen = 0;
        do begin
            @(negedge pclk);
            if (penable) pen++;
            guard++;
        end while (!rsp_valid && guard < 100);
        check("rsp_valid_bound", 32'(rsp_valid), 32'd1);
        check("psel_low_in_resp", 32'(psel), 32'd0);
    endtask

    initial begin
        int pen;
        int h1;
        int guard;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge pclk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pstrb", 32'(pstrb), 32'd0);
        preset = 1'b0;
        @(negedge pclk);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // write LCR with zero wait states, cycle-exact latency
        sl_waits = 0; sl_err = 1'b0; sl_rdata = 32'h55;
        issue(1'b1, 12'h00C, 32'h3, 4'h3, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge pclk);
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_paddr", 32'(paddr), 32'h00C);
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge pclk);
        check("access_psel", 32'(psel), 32'd1);
        check("access_penable", 32'(penable), 32'd1);
        @(negedge pclk);
        check("resp_at_n3", 32'(rsp_valid), 32'd1);
        check("resp_penable_low", 32'(penable), 32'd0);

        // read with 3 wait states; command wdata/strb must not leak onto the bus
        sl_waits = 3; sl_rdata = 32'h0A;
        issue(1'b0, 12'h010, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0A, 1'b0, 1'b0);
        wait_resp(pen);
        check("read_penable_cycles", pen, 32'd4);

        // completer error
        sl_waits = 1; sl_err = 1'b1;
        issue(1'b1, 12'h004, 32'hA5, 4'h1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_resp(pen);
        sl_err = 1'b0;

        // watchdog abort after exactly 8 ACCESS cycles
        sl_never = 1'b1; sl_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 12'h014, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        wait_resp(pen);
        check("timeout_penable_cycles", pen, 32'd8);
        check("timeout_paddr_hold", 32'(paddr), 32'h014);
        sl_never = 1'b0;

        // pready on the 8th ACCESS cycle completes normally
        sl_waits = 7; sl_rdata = 32'h77;
        issue(1'b0, 12'h014, 32'h0, 4'h0, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
        wait_resp(pen);
        check("late_ready_penable_cycles", pen, 32'd8);

        // back-to-back handshakes are 4 cycles apart
        sl_waits = 0; sl_rdata = 32'h0;
        issue(1'b1, 12'h000, 32'h41, 4'h1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        h1 = hs_cyc;
        wait_resp(pen);
        issue(1'b1, 12'h000, 32'h42, 4'h1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        check("handshake_spacing", hs_cyc - h1, 32'd4);
        wait_resp(pen);

        // response backpressure, with a new command pending during the stall
        sl_rdata = 32'h1234_5678;
        issue(1'b0, 12'h018, 32'h0, 4'h0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        wait_resp(pen);
        cmd_write = 1'b1; cmd_addr = 12'h008; cmd_wdata = 32'hC7; cmd_strb = 4'hF; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_psel", 32'(psel), 32'd0);
            @(negedge pclk);
        end
        @(posedge pclk);
        #1 rsp_ready = 1'b1;
        issue(1'b1, 12'h008, 32'hC7, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        wait_resp(pen);
        @(negedge pclk);
        check("hold_paddr", 32'(paddr), 32'h008);
        check("hold_pwdata", pwdata, 32'hC7);
        check("hold_pstrb", 32'(pstrb), 32'hF);
        check("idle_psel", 32'(psel), 32'd0);

        // reset in the middle of ACCESS
        sl_never = 1'b1;
        issue(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        guard = 0;
        while (!penable && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        check("mid_access_penable", 32'(penable), 32'd1);
        #2 preset = 1'b1;
        #1;
        check("async_rst_psel", 32'(psel), 32'd0);
        check("async_rst_penable", 32'(penable), 32'd0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        sl_never = 1'b0;
        @(negedge pclk);
        check("cmd_ready_after_mid_rst", 32'(cmd_ready), 32'd1);
        sl_waits = 2; sl_rdata = 32'h41;
        issue(1'b0, 12'h01C, 32'h0, 4'h0, 1'b1, 1'b1, 32'h41, 1'b0, 1'b0);
        wait_resp(pen);
        check("post_rst_penable_cycles", pen, 32'd3);

        @(negedge pclk);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("apb_q_drained", 32'(apb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
